mc_controller: RTL and testbench
================================

MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed by the MIPS-32 instruction format.
REQ-002 clk  input  1  single system clock; all state updates on the rising edge.
REQ-003 reset_n  input  1  reset, synchronous and active-low.
REQ-004 Op  input  6  instr[31:26] from the instruction register.
REQ-005 Funct  input  6  instr[5:0] from the instruction register.
REQ-006 Zero  input  1  ALU zero flag.
REQ-007 MemReady  input  1  memory handshake; 1 = access completes this cycle.
REQ-008 IorD  output  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-009 MemWrite, IRWrite, RegWrite, PCEn  output  1 each  write enables.
REQ-010 RegDst, MemtoReg, ALUSrcA  output  1 each  datapath mux selects.
REQ-011 ALUSrcB  output  2  ALU source B select: 00 = reg B, 01 = constant 4, 10 = SignImm, 11 = SignImm<<2.
REQ-012 PCSrc  output  2  next-PC select: 00 = ALUResult, 01 = ALUOut, 10 = PCJump.
REQ-013 ALUControl  output  3  ALU operation code, same encoding as the datapath ALU.
REQ-014 Illegal  output  1  one-cycle pulse on an undecodable instruction.
REQ-015 State  output  4  current FSM state, for debug.

Function
REQ-016 The FSM SHALL use states FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11, BNEBR=12; codes 13-15 SHALL transition to FETCH.
REQ-017 Outputs SHALL be Moore-decoded from State, except PCEn = PCWrite | (Branch & (Zero ^ BranchNe)) and the MemReady gating of REQ-018.
REQ-018 FETCH SHALL drive IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=add, PCSrc=00, and assert IRWrite and PCWrite only when MemReady=1; the FSM SHALL stay in FETCH while MemReady=0.
REQ-019 DECODE SHALL drive ALUSrcA=0, ALUSrcB=11, ALUOp=add and dispatch on Op: 100011/101011 to MEMADR, 000000 to EXECUTE, 000100 to BRANCH, 001000 to ADDIEX, 000010 to JUMP; any other Op SHALL go to FETCH with Illegal=1 for that cycle.
REQ-020 MEMADR SHALL drive ALUSrcA=1, ALUSrcB=10, ALUOp=add, then go to MEMRD (lw) or MEMWR (sw).
REQ-021 MEMRD SHALL drive IorD=1 and hold until MemReady=1, then go to MEMWB.
REQ-022 MEMWB SHALL drive RegDst=0, MemtoReg=1, RegWrite=1, then go to FETCH.
REQ-023 MEMWR SHALL drive IorD=1 and MemWrite=1 and hold until MemReady=1, then go to FETCH.
REQ-024 EXECUTE SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=funct, then go to ALUWB.
REQ-025 ALUWB SHALL drive RegDst=1, MemtoReg=0, RegWrite=1, then go to FETCH.
REQ-026 BRANCH SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=sub, Branch=1, PCSrc=01, then go to FETCH.
REQ-027 ADDIEX SHALL drive ALUSrcA=1, ALUSrcB=10, ALUOp=add, then go to ADDIWB.
REQ-028 ADDIWB SHALL drive RegDst=0, MemtoReg=0, RegWrite=1, then go to FETCH.
REQ-029 JUMP SHALL drive PCSrc=10 and PCWrite=1, then go to FETCH.
REQ-030 ALUControl decode: ALUOp=add gives 010; ALUOp=sub gives 110; ALUOp=funct maps Funct 100000->010, 100010->110, 100100->000, 100101->001, 101010->111.
REQ-031 An R-type instruction whose Funct is not one of the five listed in REQ-030 SHALL be treated as illegal in DECODE (FETCH next, Illegal=1).
REQ-032 All outputs not listed for a state SHALL be 0.
REQ-033 Latency in cycles with MemReady=1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.

Reset
REQ-034 When reset_n=0 is sampled on a rising edge, State SHALL become FETCH, regardless of the current state (including during a stall).
REQ-035 While reset_n=0, the outputs PCEn, IRWrite, MemWrite, RegWrite and Illegal SHALL be forced to 0.

Configuration
REQ-036 With macro MC_CTRL_BNE_EN defined: Op 000101 in DECODE SHALL go to BNEBR, which drives the same outputs as BRANCH with BranchNe=1 (PCEn = ~Zero); without the macro, BranchNe SHALL be 0, BNEBR SHALL be unreachable, and Op 000101 SHALL be illegal.

Verification
REQ-037 lw (Op=100011), MemReady=1: States 0,1,2,3,4 in sequence; RegWrite=1 and MemtoReg=1 in MEMWB only.
REQ-038 sw with MemReady=0 held for 3 cycles in MEMWR: MemWrite stays 1 for 4 cycles, then FETCH; RegWrite=0 throughout.
REQ-039 beq: Zero=1 gives PCEn=1 in BRANCH; Zero=0 gives PCEn=0; in both cases ALUControl=110 and PCSrc=01.
REQ-040 R-type Funct=101010: ALUControl=111 in EXECUTE; RegDst=1 and RegWrite=1 in ALUWB. Funct=000000: Illegal pulses in DECODE, then FETCH.
REQ-041 Op=000101: Illegal=1 without the macro; with MC_CTRL_BNE_EN, BNEBR is entered and Zero=0 gives PCEn=1.
REQ-042 reset_n=0 asserted while in MEMRD: FETCH on the next edge; all write enables 0 during reset.

Source files
------------

// File: rtl/mc_controller.sv
// Multicycle MIPS-32 control FSM: Moore-decoded controls, MemReady-gated fetch/memory states.
// Optional bne support is compiled in with `define MC_CTRL_BNE_EN.
module mc_controller (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       PCEn,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic [2:0] ALUControl,
    output logic       Illegal,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
        S_MEMWB   = 4'd4,  S_MEMWR  = 4'd5,  S_EXECUTE = 4'd6, S_ALUWB  = 4'd7,
        S_BRANCH  = 4'd8,  S_ADDIEX = 4'd9,  S_ADDIWB = 4'd10, S_JUMP   = 4'd11,
        S_BNEBR   = 4'd12
    } state_t;

    typedef enum logic [1:0] {ALU_NONE, ALU_ADD, ALU_SUB, ALU_FUNCT} aluop_t;

    state_t state_q, state_d;
    aluop_t alu_op;
    logic   funct_ok;
    logic   ir_write, reg_write, mem_write, pc_write, branch, branch_ne, illegal;

    always_comb begin
        funct_ok = 1'b0;
        case (Funct)
            6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: funct_ok = 1'b1;
            default: funct_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        alu_op    = ALU_NONE;
        IorD      = 1'b0;
        RegDst    = 1'b0;
        MemtoReg  = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        PCSrc     = 2'b00;
        ir_write  = 1'b0;
        reg_write = 1'b0;
        mem_write = 1'b0;
        pc_write  = 1'b0;
        branch    = 1'b0;
        branch_ne = 1'b0;
        illegal   = 1'b0;
        case (state_q)
            S_FETCH: begin
                ALUSrcB  = 2'b01;
                alu_op   = ALU_ADD;
                ir_write = MemReady;
                pc_write = MemReady;
                if (MemReady) state_d = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                alu_op  = ALU_ADD;
                case (Op)
                    6'b100011, 6'b101011: state_d = S_MEMADR;
                    6'b000000: begin
                        if (funct_ok) state_d = S_EXECUTE;
                        else begin
                            state_d = S_FETCH;
                            illegal = 1'b1;
                        end
                    end
                    6'b000100: state_d = S_BRANCH;
                    6'b001000: state_d = S_ADDIEX;
                    6'b000010: state_d = S_JUMP;
`ifdef MC_CTRL_BNE_EN
                    6'b000101: state_d = S_BNEBR;
`endif
                    default: begin
                        state_d = S_FETCH;
                        illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                alu_op  = ALU_ADD;
                state_d = (Op == 6'b101011) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                IorD = 1'b1;
                if (MemReady) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                MemtoReg  = 1'b1;
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEMWR: begin
                IorD      = 1'b1;
                mem_write = 1'b1;
                if (MemReady) state_d = S_FETCH;
            end
            S_EXECUTE: begin
                ALUSrcA = 1'b1;
                alu_op  = ALU_FUNCT;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                RegDst    = 1'b1;
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA = 1'b1;
                alu_op  = ALU_SUB;
                branch  = 1'b1;
                PCSrc   = 2'b01;
                state_d = S_FETCH;
            end
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                alu_op  = ALU_ADD;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_JUMP: begin
                PCSrc    = 2'b10;
                pc_write = 1'b1;
                state_d  = S_FETCH;
            end
`ifdef MC_CTRL_BNE_EN
            S_BNEBR: begin
                ALUSrcA   = 1'b1;
                alu_op    = ALU_SUB;
                branch    = 1'b1;
                branch_ne = 1'b1;
                PCSrc     = 2'b01;
                state_d   = S_FETCH;
            end
`endif
            default: state_d = S_FETCH;
        endcase
    end

    always_comb begin
        ALUControl = 3'b000;
        case (alu_op)
            ALU_ADD: ALUControl = 3'b010;
            ALU_SUB: ALUControl = 3'b110;
            ALU_FUNCT: begin
                case (Funct)
                    6'b100000: ALUControl = 3'b010;
                    6'b100010: ALUControl = 3'b110;
                    6'b100100: ALUControl = 3'b000;
                    6'b100101: ALUControl = 3'b001;
                    6'b101010: ALUControl = 3'b111;
                    default:   ALUControl = 3'b000;
                endcase
            end
            default: ALUControl = 3'b000;
        endcase
    end

    // Write enables and Illegal are suppressed while reset is held, even mid-stall.
    always_comb begin
        IRWrite  = ir_write  & reset_n;
        RegWrite = reg_write & reset_n;
        MemWrite = mem_write & reset_n;
        Illegal  = illegal   & reset_n;
        PCEn     = (pc_write | (branch & (Zero ^ branch_ne))) & reset_n;
        State    = state_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= S_FETCH;
        else          state_q <= state_d;
    end

endmodule

// File: tb/tb_mc_controller.sv
// Directed scoreboard bench for mc_controller; expected control words come from per-state templates.
module tb_mc_controller;

    typedef struct packed {
        logic       iord, memwrite, irwrite, regwrite, pcen, regdst, memtoreg, srca;
        logic [1:0] srcb, pcsrc;
        logic [2:0] aluctl;
        logic       illegal;
        logic [3:0] state;
    } ctl_t;

    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                           OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010,
                           OP_BNE = 6'b000101;

    logic       clk = 1'b0;
    logic       reset_n, Zero, MemReady;
    logic [5:0] Op, Funct;
    logic       IorD, MemWrite, IRWrite, RegWrite, PCEn, RegDst, MemtoReg, ALUSrcA, Illegal;
    logic [1:0] ALUSrcB, PCSrc;
    logic [2:0] ALUControl;
    logic [3:0] State;

    int unsigned checks = 0;
    int unsigned errors = 0;
    ctl_t sb_q[$];

    always #5 clk = ~clk;

    mc_controller dut (
        .clk(clk), .reset_n(reset_n), .Op(Op), .Funct(Funct), .Zero(Zero), .MemReady(MemReady),
        .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .PCEn(PCEn),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc),
        .ALUControl(ALUControl), .Illegal(Illegal), .State(State)
    );

    function automatic ctl_t e_fetch(input logic we);
        ctl_t c = '0;
        c.srcb = 2'b01; c.aluctl = 3'b010; c.irwrite = we; c.pcen = we; c.state = 4'd0;
        return c;
    endfunction
    function automatic ctl_t e_decode(input logic ill);
        ctl_t c = '0;
        c.srcb = 2'b11; c.aluctl = 3'b010; c.illegal = ill; c.state = 4'd1;
        return c;
    endfunction
    function automatic ctl_t e_memadr();
        ctl_t c = '0;
        c.srca = 1'b1; c.srcb = 2'b10; c.aluctl = 3'b010; c.state = 4'd2;
        return c;
    endfunction
    function automatic ctl_t e_memrd();
        ctl_t c = '0;
        c.iord = 1'b1; c.state = 4'd3;
        return c;
    endfunction
    function automatic ctl_t e_memwb();
        ctl_t c = '0;
        c.memtoreg = 1'b1; c.regwrite = 1'b1; c.state = 4'd4;
        return c;
    endfunction
    function automatic ctl_t e_memwr(input logic we);
        ctl_t c = '0;
        c.iord = 1'b1; c.memwrite = we; c.state = 4'd5;
        return c;
    endfunction
    function automatic ctl_t e_execute(input logic [2:0] alu);
        ctl_t c = '0;
        c.srca = 1'b1; c.aluctl = alu; c.state = 4'd6;
        return c;
    endfunction
    function automatic ctl_t e_aluwb();
        ctl_t c = '0;
        c.regdst = 1'b1; c.regwrite = 1'b1; c.state = 4'd7;
        return c;
    endfunction
    function automatic ctl_t e_branch(input logic pcen, input logic [3:0] st);
        ctl_t c = '0;
        c.srca = 1'b1; c.aluctl = 3'b110; c.pcsrc = 2'b01; c.pcen = pcen; c.state = st;
        return c;
    endfunction
    function automatic ctl_t e_addiex();
        ctl_t c = '0;
        c.srca = 1'b1; c.srcb = 2'b10; c.aluctl = 3'b010; c.state = 4'd9;
        return c;
    endfunction
    function automatic ctl_t e_addiwb();
        ctl_t c = '0;
        c.regwrite = 1'b1; c.state = 4'd10;
        return c;
    endfunction
    function automatic ctl_t e_jump();
        ctl_t c = '0;
        c.pcsrc = 2'b10; c.pcen = 1'b1; c.state = 4'd11;
        return c;
    endfunction

    task automatic step(input string tag, input logic [5:0] op, input logic [5:0] funct,
                        input logic z, input logic mr, input logic rn, input ctl_t e);
        ctl_t obs, ex;
        @(negedge clk);
        Op = op; Funct = funct; Zero = z; MemReady = mr; reset_n = rn;
        sb_q.push_back(e);
        #2;
        obs = {IorD, MemWrite, IRWrite, RegWrite, PCEn, RegDst, MemtoReg, ALUSrcA,
               ALUSrcB, PCSrc, ALUControl, Illegal, State};
        ex = sb_q.pop_front();
        checks++;
        assert (obs === ex) else begin
            errors++;
            $error("FAIL %s observed=%05h expected=%05h", tag, obs, ex);
        end
    endtask

    initial begin
        reset_n = 1'b0; Op = '0; Funct = '0; Zero = 1'b0; MemReady = 1'b0;
        @(posedge clk);

        step("rst_fetch", OP_LW, 6'd0, 1'b0, 1'b1, 1'b0, e_fetch(1'b0));
        step("fetch_stall", OP_LW, 6'd0, 1'b0, 1'b0, 1'b1, e_fetch(1'b0));
        step("lw_fetch", OP_LW, 6'd0, 1'b0, 1'b1, 1'b1, e_fetch(1'b1));
        step("lw_decode", OP_LW, 6'd0, 1'b0, 1'b1, 1'b1, e_decode(1'b0));
        step("lw_memadr", OP_LW, 6'd0, 1'b0, 1'b1, 1'b1, e_memadr());
        step("lw_memrd", OP_LW, 6'd0, 1'b0, 1'b1, 1'b1, e_memrd());
        step("lw_memwb", OP_LW, 6'd0, 1'b0, 1'b1, 1'b1, e_memwb());

        step("sw_fetch", OP_SW, 6'd0, 1'b0, 1'b1, 1'b1, e_fetch(1'b1));
        step("sw_decode", OP_SW, 6'd0, 1'b0, 1'b1, 1'b1, e_decode(1'b0));
        step("sw_memadr", OP_SW, 6'd0, 1'b0, 1'b0, 1'b1, e_memadr());
        for (int i = 0; i < 3; i++)
            step("sw_memwr_stall", OP_SW, 6'd0, 1'b0, 1'b0, 1'b1, e_memwr(1'b1));
        step("sw_memwr_done", OP_SW, 6'd0, 1'b0, 1'b1, 1'b1, e_memwr(1'b1));

        step("beq1_fetch", OP_BEQ, 6'd0, 1'b1, 1'b1, 1'b1, e_fetch(1'b1));
        step("beq1_decode", OP_BEQ, 6'd0, 1'b1, 1'b1, 1'b1, e_decode(1'b0));
        step("beq_taken", OP_BEQ, 6'd0, 1'b1, 1'b1, 1'b1, e_branch(1'b1, 4'd8));
        step("beq0_fetch", OP_BEQ, 6'd0, 1'b0, 1'b1, 1'b1, e_fetch(1'b1));
        step("beq0_decode", OP_BEQ, 6'd0, 1'b0, 1'b1, 1'b1, e_decode(1'b0));
        step("beq_not_taken", OP_BEQ, 6'd0, 1'b0, 1'b1, 1'b1, e_branch(1'b0, 4'd8));

        step("slt_fetch", OP_R, 6'b101010, 1'b0, 1'b1, 1'b1, e_fetch(1'b1));
        step("slt_decode", OP_R, 6'b101010, 1'b0, 1'b1, 1'b1, e_decode(1'b0));
        step("slt_execute", OP_R, 6'b101010, 1'b0, 1'b1, 1'b1, e_execute(3'b111));
        step("slt_aluwb", OP_R, 6'b101010, 1'b0, 1'b1, 1'b1, e_aluwb());
        step("or_fetch", OP_R, 6'b100101, 1'b0, 1'b1, 1'b1, e_fetch(1'b1));
        step("or_decode", OP_R, 6'b100101, 1'b0, 1'b1, 1'b1, e_decode(1'b0));
        step("or_execute", OP_R, 6'b100101, 1'b0, 1'b1, 1'b1, e_execute(3'b001));
        step("or_aluwb", OP_R, 6'b100101, 1'b0, 1'b1, 1'b1, e_aluwb());
        step("badfn_fetch", OP_R, 6'b000000, 1'b0, 1'b1, 1'b1, e_fetch(1'b1));
        step("badfn_decode", OP_R, 6'b000000, 1'b0, 1'b1, 1'b1, e_decode(1'b1));

        step("addi_fetch", OP_ADDI, 6'd0, 1'b0, 1'b1, 1'b1, e_fetch(1'b1));
        step("addi_decode", OP_ADDI, 6'd0, 1'b0, 1'b1, 1'b1, e_decode(1'b0));
        step("addi_ex", OP_ADDI, 6'd0, 1'b0, 1'b1, 1'b1, e_addiex());
        step("addi_wb", OP_ADDI, 6'd0, 1'b0, 1'b1, 1'b1, e_addiwb());

        step("j_fetch", OP_J, 6'd0, 1'b0, 1'b1, 1'b1, e_fetch(1'b1));
        step("j_decode", OP_J, 6'd0, 1'b0, 1'b1, 1'b1, e_decode(1'b0));
        step("j_jump", OP_J, 6'd0, 1'b0, 1'b1, 1'b1, e_jump());

        step("bne_fetch", OP_BNE, 6'd0, 1'b0, 1'b1, 1'b1, e_fetch(1'b1));
`ifdef MC_CTRL_BNE_EN
        step("bne_decode", OP_BNE, 6'd0, 1'b0, 1'b1, 1'b1, e_decode(1'b0));
        step("bne_taken", OP_BNE, 6'd0, 1'b0, 1'b1, 1'b1, e_branch(1'b1, 4'd12));
`else
        step("bne_illegal", OP_BNE, 6'd0, 1'b0, 1'b1, 1'b1, e_decode(1'b1));
`endif
        step("badop_fetch", 6'b111111, 6'd0, 1'b0, 1'b1, 1'b1, e_fetch(1'b1));
        step("badop_decode", 6'b111111, 6'd0, 1'b0, 1'b1, 1'b1, e_decode(1'b1));
        step("badop_refetch", OP_LW, 6'd0, 1'b0, 1'b1, 1'b0, e_fetch(1'b0));

        step("rdrst_fetch", OP_LW, 6'd0, 1'b0, 1'b1, 1'b1, e_fetch(1'b1));
        step("rdrst_decode", OP_LW, 6'd0, 1'b0, 1'b1, 1'b1, e_decode(1'b0));
        step("rdrst_memadr", OP_LW, 6'd0, 1'b0, 1'b0, 1'b1, e_memadr());
        step("rdrst_memrd_stall", OP_LW, 6'd0, 1'b0, 1'b0, 1'b1, e_memrd());
        step("rdrst_memrd_in_reset", OP_LW, 6'd0, 1'b0, 1'b0, 1'b0, e_memrd());
        step("rdrst_back_to_fetch", OP_LW, 6'd0, 1'b0, 1'b0, 1'b1, e_fetch(1'b0));

        step("wrrst_fetch", OP_SW, 6'd0, 1'b0, 1'b1, 1'b1, e_fetch(1'b1));
        step("wrrst_decode", OP_SW, 6'd0, 1'b0, 1'b1, 1'b1, e_decode(1'b0));
        step("wrrst_memadr", OP_SW, 6'd0, 1'b0, 1'b0, 1'b1, e_memadr());
        step("wrrst_memwr_in_reset", OP_SW, 6'd0, 1'b0, 1'b0, 1'b0, e_memwr(1'b0));
        step("wrrst_back_to_fetch", OP_SW, 6'd0, 1'b0, 1'b1, 1'b1, e_fetch(1'b1));

        step("illrst_decode", 6'b111111, 6'd0, 1'b0, 1'b1, 1'b0, e_decode(1'b0));
        step("illrst_fetch", 6'b111111, 6'd0, 1'b0, 1'b0, 1'b1, e_fetch(1'b0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
